rotary_multi_ctl: RTL

Parametrised multi-dial quadrature controller for the display board rotary dials. It replaces the pair of fixed two-dial controllers with one block handling `NUM_DIALS` encoders, each with:
- synchronisation and debounce
- a configurable steps-per-event ratio
- a wrap or saturate position counter
- direction pulses and a sticky illegal-transition flag

It sits between the `DIALL`/`DIALR` pins and the SoC interconnect/PIO that reads positions.

---
 rtl/rotary_pkg.sv | 39 +++
 rtl/rotary_multi_ctl_channel.sv | 178 +++++++++++++++++
 rtl/rotary_multi_ctl.sv | 57 +++++
 3 files changed

// File: rtl/rotary_pkg.sv
// Shared types and the quadrature step decoder for the rotary dial controller.
package rotary_pkg;

    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_CW,
        STEP_CCW,
        STEP_ILLEGAL
    } step_t;

    // Clockwise order of {B,A}: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic quad_t cw_successor(input quad_t q);
        quad_t nxt;
        case (q)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic step_t quad_decode(input quad_t prev, input quad_t curr);
        step_t step;
        if (prev == curr) begin
            step = STEP_NONE;
        end else if ((prev ^ curr) == 2'b11) begin
            step = STEP_ILLEGAL;
        end else if (curr == cw_successor(prev)) begin
            step = STEP_CW;
        end else begin
            step = STEP_CCW;
        end
        return step;
    endfunction

endpackage

// File: rtl/rotary_multi_ctl_channel.sv
// One dial: synchroniser, per-bit debouncer, priming, step decode, accumulator,
// position counter, direction pulses and sticky error flag.
module rotary_channel
    import rotary_pkg::*;
#(
    parameter int COUNT_W         = 8,
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int STEPS_PER_EVENT = 4,
    parameter int WRAP            = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         rotary_in,
    input  logic               clear,
    output logic [COUNT_W-1:0] position,
    output logic               rotary_cw,
    output logic               rotary_ccw,
    output logic               error,
    output logic               event_next
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The decode stage sees a debounced change one cycle after it lands, so the
    // gate must stay closed one cycle past the latest possible initial update.
    localparam int PRIME_CYCLES = DEBOUNCE_CYCLES + 3;
    localparam int PRIME_W      = $clog2(PRIME_CYCLES + 2);
    localparam int ACC_W        = 4;
    localparam logic signed [ACC_W-1:0] ACC_SPE = ACC_W'(STEPS_PER_EVENT);
    localparam logic signed [ACC_W-1:0] ACC_ONE = 4'sd1;

    logic [1:0]               r_sync1;
    logic [1:0]               r_sync2;
    quad_t                    w_stable;
    quad_t                    r_ref;
    logic [PRIME_W-1:0]       r_prime_cnt;
    logic                     r_primed;
    logic signed [ACC_W-1:0]  r_acc;
    logic [COUNT_W-1:0]       r_pos;
    logic                     r_cw;
    logic                     r_ccw;
    logic                     r_err;

    step_t                    w_step;
    logic signed [ACC_W-1:0]  w_acc_step;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_cw_next;
    logic                     w_ccw_next;
    logic                     w_err_set;
    logic [COUNT_W-1:0]       w_pos_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= rotary_in;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_db
            logic [DB_W-1:0] r_cnt;
            logic            r_level;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_sync2[gi] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                    r_level <= r_sync2[gi];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_stable[gi] = r_level;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prime_cnt <= '0;
            r_primed    <= 1'b0;
        end else if (!r_primed) begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
            if (r_prime_cnt == PRIME_W'(PRIME_CYCLES)) begin
                r_primed <= 1'b1;
            end
        end
    end

    // Before priming the reference silently tracks the debounced level.
    assign w_step = r_primed ? quad_decode(r_ref, w_stable) : STEP_NONE;

    always_comb begin
        w_acc_step = '0;
        w_acc_next = r_acc;
        w_cw_next  = 1'b0;
        w_ccw_next = 1'b0;
        w_err_set  = 1'b0;
        case (w_step)
            STEP_CW: begin
                w_acc_step = r_acc[ACC_W-1] ? ACC_ONE : (r_acc + ACC_ONE);
                if (w_acc_step == ACC_SPE) begin
                    w_cw_next  = 1'b1;
                    w_acc_next = '0;
                end else begin
                    w_acc_next = w_acc_step;
                end
            end
            STEP_CCW: begin
                w_acc_step = (!r_acc[ACC_W-1] && (r_acc != '0)) ? -ACC_ONE : (r_acc - ACC_ONE);
                if (w_acc_step == -ACC_SPE) begin
                    w_ccw_next = 1'b1;
                    w_acc_next = '0;
                end else begin
                    w_acc_next = w_acc_step;
                end
            end
            STEP_ILLEGAL: begin
                w_err_set  = 1'b1;
                w_acc_next = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_pos_next = r_pos;
        if (w_cw_next) begin
            if ((WRAP != 0) || (r_pos != '1)) begin
                w_pos_next = r_pos + 1'b1;
            end
        end else if (w_ccw_next) begin
            if ((WRAP != 0) || (r_pos != '0)) begin
                w_pos_next = r_pos - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref <= 2'b00;
            r_acc <= '0;
            r_pos <= '0;
            r_cw  <= 1'b0;
            r_ccw <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ref <= w_stable;
            r_cw  <= w_cw_next;
            r_ccw <= w_ccw_next;
            // Clear wins over a coincident event: the pulse fires, position stays 0.
            if (clear) begin
                r_acc <= '0;
                r_pos <= '0;
                r_err <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_pos <= w_pos_next;
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign position   = r_pos;
    assign rotary_cw  = r_cw;
    assign rotary_ccw = r_ccw;
    assign error      = r_err;
    assign event_next = w_cw_next | w_ccw_next;

endmodule

// File: rtl/rotary_multi_ctl.sv
// Multi-dial quadrature controller: one rotary_channel per dial plus the
// combined event flag, registered so it lines up with the per-dial pulses.
module rotary_multi_ctl
    import rotary_pkg::*;
#(
    parameter int NUM_DIALS       = 2,
    parameter int COUNT_W         = 8,
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int STEPS_PER_EVENT = 4,
    parameter int WRAP            = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2*NUM_DIALS-1:0]         rotary_in,
    input  logic [NUM_DIALS-1:0]           clear,
    output logic [NUM_DIALS*COUNT_W-1:0]   position,
    output logic [NUM_DIALS-1:0]           rotary_cw,
    output logic [NUM_DIALS-1:0]           rotary_ccw,
    output logic [NUM_DIALS-1:0]           error,
    output logic                           any_event
);

    logic [NUM_DIALS-1:0] w_event_next;
    logic                 r_any_event;

    generate
        for (genvar gi = 0; gi < NUM_DIALS; gi++) begin : g_dial
            rotary_channel #(
                .COUNT_W        (COUNT_W),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .STEPS_PER_EVENT(STEPS_PER_EVENT),
                .WRAP           (WRAP)
            ) u_channel (
                .clk       (clk),
                .reset     (reset),
                .rotary_in (rotary_in[2*gi +: 2]),
                .clear     (clear[gi]),
                .position  (position[gi*COUNT_W +: COUNT_W]),
                .rotary_cw (rotary_cw[gi]),
                .rotary_ccw(rotary_ccw[gi]),
                .error     (error[gi]),
                .event_next(w_event_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any_event <= 1'b0;
        end else begin
            r_any_event <= |w_event_next;
        end
    end

    assign any_event = r_any_event;

endmodule
